// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared types and constants for the Hi/Lo multiply/divide sequencer.
//   state_t   : controller states (IDLE, MULT, DIV, FIX, DONE)
//   mode_t    : which iteration the datapath performs (multiply or divide)
//   DEF_WIDTH : default operand width
//   DEF_CNT_W : iteration counter width for DEF_WIDTH
//   cnt_width : iteration counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        MODE_MULT,
        MODE_DIV
    } mode_t;

    // The counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// -----------------------------------------------------------------------------
// mult_div_if
// Start/operand/result bundle between the CPU main control FSM and the Hi/Lo
// multiply/divide sequencer.
//   mult_start, div_start : one-cycle start pulses from the control FSM
//   op_a, op_b            : operands (register A / register B outputs)
//   op_unsigned           : multu/divu select, present only when the
//                           MULT_DIV_UNSIGNED_EN macro is defined
//   busy, done, div_zero  : status back to the control FSM
//   hilo_write            : Hi/Lo update strobe
//   hi_out, lo_out        : Hi and Lo register contents
// Modports: master = control FSM side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface mult_div_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef MULT_DIV_UNSIGNED_EN
    logic             op_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hilo_write;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

`ifdef MULT_DIV_UNSIGNED_EN
    modport master (
        output mult_start, div_start, op_a, op_b, op_unsigned,
        input  busy, done, div_zero, hilo_write, hi_out, lo_out
    );
    modport slave (
        input  mult_start, div_start, op_a, op_b, op_unsigned,
        output busy, done, div_zero, hilo_write, hi_out, lo_out
    );
`else
    modport master (
        output mult_start, div_start, op_a, op_b,
        input  busy, done, div_zero, hilo_write, hi_out, lo_out
    );
    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output busy, done, div_zero, hilo_write, hi_out, lo_out
    );
`endif

endinterface

// File: rtl/mult_div_core.sv
// -----------------------------------------------------------------------------
// mult_div_core
// Iteration datapath for the Hi/Lo sequencer: a 2*WIDTH accumulator
// {hi, lo}, an operand register, a shift-add multiplier step, a restoring
// divider step and a final sign-fix step. Works on magnitudes only; the
// controller decides what to load and which results to negate.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   load          : acc <= {0, load_lo}, operand <= load_opnd
//   step          : one multiply or divide iteration, selected by mode
//   fix           : negate results (mult: whole product on neg_lo;
//                   div: lo on neg_lo, hi on neg_hi)
//   mode          : MODE_MULT or MODE_DIV
//   load_lo       : multiplier (mult) or dividend (div) magnitude
//   load_opnd     : multiplicand (mult) or divisor (div) magnitude
//   hi, lo        : accumulator halves (product / remainder:quotient)
// -----------------------------------------------------------------------------
module mult_div_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  mode_t            mode,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_opnd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_next;

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    // Multiply: add the multiplicand into hi when the multiplier LSB is set,
    // then shift {carry, hi, lo} right one place. The multiplier bits are
    // consumed from lo as the product bits fill in from the top.
    assign mult_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mult_next = {mult_sum, lo[WIDTH-1:1]};

    // Divide: shift {rem, quo} left, trial-subtract the divisor. When the
    // shifted remainder has its top bit set it exceeds any WIDTH-bit divisor,
    // and the true difference is below 2^WIDTH, so a WIDTH-bit subtract is
    // exact whenever the trial succeeds.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign div_fits  = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= opnd);
    assign div_next  = div_fits ? {div_diff, lo[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};

    always_comb begin
        fix_next = acc;
        if (mode == MODE_MULT) begin
            if (neg_lo) fix_next = -acc;
        end else begin
            fix_next = {(neg_hi ? -hi : hi), (neg_lo ? -lo : lo)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, load_lo};
            opnd <= load_opnd;
        end else if (step) begin
            acc  <= (mode == MODE_DIV) ? div_next : mult_next;
        end else if (fix) begin
            acc  <= fix_next;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl
// Sequencer for the CPU Hi/Lo multiply/divide resource. Takes start pulses
// from the main control FSM, runs WIDTH iterations in mult_div_core, fixes
// the signs, then writes Hi/Lo. Divide by zero skips the iterations and
// reports div_zero with done, leaving Hi/Lo untouched.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset; abandons any operation
//   bus   : mult_div_if.slave (starts, operands, status, Hi/Lo)
// Optional: MULT_DIV_UNSIGNED_EN adds bus.op_unsigned (multu/divu), sampled
// with the start pulse; when set, no magnitude or negation is applied.
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for mult_start / div_start
// MULT  | one shift-add step per cycle, counter WIDTH..1
// DIV   | one restoring step per cycle, counter WIDTH..1
// FIX   | negate magnitude results according to the latched signs
// DONE  | done pulse; Hi/Lo written at the end of this cycle unless div_zero
// -----------------------------------------------------------------------------
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic       clk,
    input logic       reset,
    mult_div_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    mode_t            mode;
    logic             res_sign;
    logic             rem_sign;
    logic             zero_flag;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             uns;
    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             take_mult;
    logic             take_div;
    logic             take_dz;
    logic             core_load;
    logic             core_step;
    logic             core_fix;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns = bus.op_unsigned;
`else
    assign uns = 1'b0;
`endif

    // Unsigned magnitudes: |-2^(WIDTH-1)| = 2^(WIDTH-1) fits without overflow.
    assign a_sign = bus.op_a[WIDTH-1] & ~uns;
    assign b_sign = bus.op_b[WIDTH-1] & ~uns;
    assign a_mag  = a_sign ? -bus.op_a : bus.op_a;
    assign b_mag  = b_sign ? -bus.op_b : bus.op_b;

    always_comb begin
        state_nxt = state;
        take_mult = 1'b0;
        take_div  = 1'b0;
        take_dz   = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        core_fix  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mult_start) begin
                    take_mult = 1'b1;
                    core_load = 1'b1;
                    state_nxt = MULT;
                end else if (bus.div_start) begin
                    if (bus.op_b == '0) begin
                        take_dz   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        take_div  = 1'b1;
                        core_load = 1'b1;
                        state_nxt = DIV;
                    end
                end
            end
            MULT, DIV: begin
                core_step = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = FIX;
            end
            FIX: begin
                core_fix  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            mode      <= MODE_MULT;
            res_sign  <= 1'b0;
            rem_sign  <= 1'b0;
            zero_flag <= 1'b0;
        end else if (take_mult) begin
            cnt       <= CNT_W'(WIDTH);
            mode      <= MODE_MULT;
            res_sign  <= a_sign ^ b_sign;
            rem_sign  <= 1'b0;
            zero_flag <= 1'b0;
        end else if (take_div) begin
            cnt       <= CNT_W'(WIDTH);
            mode      <= MODE_DIV;
            res_sign  <= a_sign ^ b_sign;
            rem_sign  <= a_sign;
            zero_flag <= 1'b0;
        end else if (take_dz) begin
            cnt       <= '0;
            mode      <= MODE_DIV;
            res_sign  <= 1'b0;
            rem_sign  <= 1'b0;
            zero_flag <= 1'b1;
        end else if (core_step) begin
            cnt       <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == DONE && !zero_flag) begin
            hi_reg <= core_hi;
            lo_reg <= core_lo;
        end
    end

    // Multiplicand/divisor goes to the operand register; multiplier/dividend
    // is shifted through lo.
    mult_div_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .fix       (core_fix),
        .mode      (mode),
        .neg_hi    ((mode == MODE_DIV) ? rem_sign : res_sign),
        .neg_lo    (res_sign),
        .load_lo   (take_div ? a_mag : b_mag),
        .load_opnd (take_div ? b_mag : a_mag),
        .hi        (core_hi),
        .lo        (core_lo)
    );

    assign bus.busy       = (state == MULT) || (state == DIV) || (state == FIX);
    assign bus.done       = (state == DONE);
    assign bus.div_zero   = (state == DONE) && zero_flag;
    assign bus.hilo_write = (state == DONE) && !zero_flag;
    assign bus.hi_out     = hi_reg;
    assign bus.lo_out     = lo_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: each operation pushes its expected Hi/Lo, flags and
// latency onto a scoreboard; the result is popped and compared when done fires.
module tb_mult_div_ctrl;
    import mult_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;
    int           n_checks;
    int           n_pass;

    logic         obs_timeout;
    int           obs_lat;
    int           obs_busy;
    logic         obs_dz;
    logic         obs_hw;
    logic [W-1:0] obs_hi;
    logic [W-1:0] obs_lo;
    logic         obs_hw_after;

    // Drive one start pulse (sampled at the next rising edge) and push the
    // expected outcome computed with 64-bit signed arithmetic.
    task automatic issue(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] v;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            v = p;
            e.hi = v[63:32]; e.lo = v[31:0]; e.dz = 1'b0; e.lat = LAT;
        end else if (b == '0) begin
            e.hi = model_hi; e.lo = model_lo; e.dz = 1'b1; e.lat = 1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            v = q; e.lo = v[31:0];
            v = r; e.hi = v[31:0];
            e.dz = 1'b0; e.lat = LAT;
        end
        if (!e.dz) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
        sb.push_back(e);
        @(negedge clk);
        bus.mult_start = m;
        bus.div_start  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
    endtask

    // Observe one operation; optionally inject a div_start (and scramble the
    // operands) in cycle inject_at after the start edge.
    task automatic wait_done(input int inject_at);
        obs_timeout = 1'b1;
        obs_lat     = 0;
        obs_busy    = 0;
        obs_dz      = 1'b0;
        obs_hw      = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.busy) obs_busy++;
            if (bus.done) begin
                obs_timeout = 1'b0;
                obs_lat     = c;
                obs_dz      = bus.div_zero;
                obs_hw      = bus.hilo_write;
                break;
            end
            if (c == inject_at) begin
                bus.div_start = 1'b1;
                bus.op_a      = $urandom;
                bus.op_b      = '0;
            end else begin
                bus.div_start = 1'b0;
            end
        end
        bus.div_start = 1'b0;
        @(negedge clk);
        obs_hi       = bus.hi_out;
        obs_lo       = bus.lo_out;
        obs_hw_after = bus.hilo_write;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b expected 0", bus.done); else n_pass++;
        n_checks++; if (bus.div_zero !== 1'b0) $display("FAIL reset div_zero: got %b expected 0", bus.div_zero); else n_pass++;
        n_checks++; if (bus.hilo_write !== 1'b0) $display("FAIL reset hilo_write: got %b expected 0", bus.hilo_write); else n_pass++;
        n_checks++; if (bus.hi_out !== '0) $display("FAIL reset hi: got %h expected 0", bus.hi_out); else n_pass++;
        n_checks++; if (bus.lo_out !== '0) $display("FAIL reset lo: got %h expected 0", bus.lo_out); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        logic [W-1:0] ta [4] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [W-1:0] tb [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9ABC_DEF0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, ta[i], tb[i]);
            wait_done(0);
            e = sb.pop_front();
            n_checks++; if (obs_timeout !== 1'b0) $display("FAIL mult%0d timeout: no done in 100 cycles", i); else n_pass++;
            n_checks++; if (obs_lat != e.lat) $display("FAIL mult%0d latency: got %0d expected %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_busy != W + 1) $display("FAIL mult%0d busy cycles: got %0d expected %0d", i, obs_busy, W + 1); else n_pass++;
            n_checks++; if (obs_dz !== 1'b0) $display("FAIL mult%0d div_zero: got %b expected 0", i, obs_dz); else n_pass++;
            n_checks++; if (obs_hw !== 1'b1) $display("FAIL mult%0d hilo_write: got %b expected 1", i, obs_hw); else n_pass++;
            n_checks++; if (obs_hw_after !== 1'b0) $display("FAIL mult%0d hilo_write width: got %b after done expected 0", i, obs_hw_after); else n_pass++;
            n_checks++; if (obs_hi !== e.hi) $display("FAIL mult%0d hi: got %h expected %h", i, obs_hi, e.hi); else n_pass++;
            n_checks++; if (obs_lo !== e.lo) $display("FAIL mult%0d lo: got %h expected %h", i, obs_lo, e.lo); else n_pass++;
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064, 32'h9ABC_DEF0};
        logic [W-1:0] tb [4] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0000_1234};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, ta[i], tb[i]);
            wait_done(0);
            e = sb.pop_front();
            n_checks++; if (obs_timeout !== 1'b0) $display("FAIL div%0d timeout: no done in 100 cycles", i); else n_pass++;
            n_checks++; if (obs_lat != e.lat) $display("FAIL div%0d latency: got %0d expected %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_dz !== 1'b0) $display("FAIL div%0d div_zero: got %b expected 0", i, obs_dz); else n_pass++;
            n_checks++; if (obs_hw !== 1'b1) $display("FAIL div%0d hilo_write: got %b expected 1", i, obs_hw); else n_pass++;
            n_checks++; if (obs_hi !== e.hi) $display("FAIL div%0d hi: got %h expected %h", i, obs_hi, e.hi); else n_pass++;
            n_checks++; if (obs_lo !== e.lo) $display("FAIL div%0d lo: got %h expected %h", i, obs_lo, e.lo); else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        issue(1'b0, 1'b1, 32'h0000_2211, 32'h0000_0100);
        wait_done(0);
        e = sb.pop_front();
        n_checks++; if (obs_hi !== 32'h11 || obs_lo !== 32'h22) $display("FAIL dz preload: got %h/%h expected 00000011/00000022", obs_hi, obs_lo); else n_pass++;
        issue(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000);
        wait_done(0);
        e = sb.pop_front();
        n_checks++; if (obs_timeout !== 1'b0) $display("FAIL dz timeout: no done in 100 cycles"); else n_pass++;
        n_checks++; if (obs_lat != e.lat) $display("FAIL dz latency: got %0d expected %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_busy != 0) $display("FAIL dz busy cycles: got %0d expected 0", obs_busy); else n_pass++;
        n_checks++; if (obs_dz !== 1'b1) $display("FAIL dz div_zero: got %b expected 1", obs_dz); else n_pass++;
        n_checks++; if (obs_hw !== 1'b0) $display("FAIL dz hilo_write: got %b expected 0", obs_hw); else n_pass++;
        n_checks++; if (obs_hi !== e.hi) $display("FAIL dz hi: got %h expected %h", obs_hi, e.hi); else n_pass++;
        n_checks++; if (obs_lo !== e.lo) $display("FAIL dz lo: got %h expected %h", obs_lo, e.lo); else n_pass++;
    endtask

    // Scenario 0: div_start during iteration 5 of a multiply.
    // Scenario 1: both starts in the same cycle.
    task automatic test_boundary();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) issue(1'b1, 1'b0, 32'hFFFF_FFF5, 32'h0000_0D05);
            else        issue(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0007);
            wait_done(s == 0 ? 5 : 0);
            e = sb.pop_front();
            n_checks++; if (obs_lat != e.lat) $display("FAIL boundary%0d latency: got %0d expected %0d", s, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_dz !== 1'b0) $display("FAIL boundary%0d div_zero: got %b expected 0", s, obs_dz); else n_pass++;
            n_checks++; if (obs_hi !== e.hi) $display("FAIL boundary%0d hi: got %h expected %h", s, obs_hi, e.hi); else n_pass++;
            n_checks++; if (obs_lo !== e.lo) $display("FAIL boundary%0d lo: got %h expected %h", s, obs_lo, e.lo); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   seen_done;
        issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'h0000_0003);
        wait_done(0);
        e = sb.pop_front();
        n_checks++; if (obs_hi !== e.hi || obs_lo !== e.lo) $display("FAIL areset pre-op: got %h/%h expected %h/%h", obs_hi, obs_lo, e.hi, e.lo); else n_pass++;
        issue(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0077);
        seen_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL areset busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.hi_out !== '0) $display("FAIL areset hi: got %h expected 0", bus.hi_out); else n_pass++;
        n_checks++; if (bus.lo_out !== '0) $display("FAIL areset lo: got %h expected 0", bus.lo_out); else n_pass++;
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        rst_n = 1'b1;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        n_checks++; if (seen_done != 0) $display("FAIL areset abandoned: got %0d done/busy cycles expected 0", seen_done); else n_pass++;
        issue(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
        wait_done(0);
        e = sb.pop_front();
        n_checks++; if (obs_lat != e.lat) $display("FAIL areset post latency: got %0d expected %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_hi !== e.hi) $display("FAIL areset post hi: got %h expected %h", obs_hi, e.hi); else n_pass++;
        n_checks++; if (obs_lo !== e.lo) $display("FAIL areset post lo: got %h expected %h", obs_lo, e.lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 4) ? '0 : $urandom;
            issue(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b1 : 1'b0, a, b);
            wait_done(0);
            e = sb.pop_front();
            n_checks++; if (obs_lat != e.lat) $display("FAIL b2b%0d latency: got %0d expected %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_dz !== e.dz) $display("FAIL b2b%0d div_zero: got %b expected %b", i, obs_dz, e.dz); else n_pass++;
            n_checks++; if (obs_hi !== e.hi) $display("FAIL b2b%0d hi: got %h expected %h (a=%h b=%h)", i, obs_hi, e.hi, a, b); else n_pass++;
            n_checks++; if (obs_lo !== e.lo) $display("FAIL b2b%0d lo: got %h expected %h (a=%h b=%h)", i, obs_lo, e.lo, a, b); else n_pass++;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        model_hi       = '0;
        model_lo       = '0;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.op_unsigned = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_boundary();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
